// File: rtl/bus_launch_ctrl_if.sv
// Handshake and launch-bus signals between local source logic and bus_launch_ctrl.
interface bus_launch_ctrl_if #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned DEPTH     = 4
);
  logic [BUS_WIDTH-1:0]     in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [BUS_WIDTH-1:0]     src_bus_out;
  logic                     src_bus_enable;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  in_data, in_valid,
    output in_ready, src_bus_out, src_bus_enable, busy, fifo_count
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, src_bus_out, src_bus_enable, busy, fifo_count
  );
endinterface

// File: rtl/bus_launch_ctrl.sv
// Buffers words and launches each onto a registered bus with a held enable level,
// giving a destination-domain synchronizer a stable data/enable window per word.
module bus_launch_ctrl #(
  parameter int unsigned BUS_WIDTH   = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned GAP_CYCLES  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  bus_launch_ctrl_if.slave bus
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned MaxTime = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW    = $clog2(MaxTime + 1);

  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
  localparam logic [TmrW-1:0] HoldLast  = TmrW'(HOLD_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAssert, StGap} state_e;

  state_e                state_q, state_d;
  logic [BUS_WIDTH-1:0]  mem_q [DEPTH];
  logic [BUS_WIDTH-1:0]  mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [TmrW-1:0]       tmr_q, tmr_d;
  logic [BUS_WIDTH-1:0]  out_q, out_d;
  logic                  en_q, en_d;
  logic                  in_ready;
  logic                  busy;
  logic                  push;
  logic                  pop;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StSetup;
      end
      StSetup: begin
        state_d = StAssert;
        tmr_d   = '0;
      end
      StAssert: begin
        if (tmr_q == HoldLast) begin
          state_d = StGap;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; in_ready deliberately ignores a same-cycle pop
  always_comb begin
    in_ready = RST && (count_q != CountFull);
    busy     = (state_q != StIdle) || (count_q != '0);
    push     = bus.in_valid && in_ready;
    pop      = (state_q == StIdle) && (count_q != '0);
    // Enable is registered from the next state so it is high exactly while in StAssert
    en_d     = (state_d == StAssert);
  end

  // Buffer and launch-register next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      en_q     <= en_d;
    end
  end

  // Storage needs no reset: the count and pointers gate every read
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready       = in_ready;
  assign bus.busy           = busy;
  assign bus.src_bus_out    = out_q;
  assign bus.src_bus_enable = en_q;
  assign bus.fifo_count     = count_q;

endmodule

// File: tb/tb_bus_launch_ctrl.sv
// Randomized bench for bus_launch_ctrl against a queue-and-age reference model,
// plus directed single-word, burst/full and reset-abort sequences.
module tb_bus_launch_ctrl;
  localparam int unsigned W = 4;
  localparam int unsigned D = 4;
  localparam int unsigned H = 3;
  localparam int unsigned G = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_launch_ctrl_if #(.BUS_WIDTH(W), .DEPTH(D)) bus_if ();

  bus_launch_ctrl #(
    .BUS_WIDTH  (W),
    .DEPTH      (D),
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered words, plus cycles elapsed since the current word was popped
  logic [W-1:0] mq[$];
  int           age   = 0;
  logic [W-1:0] m_out = '0;

  logic             s_rdy, s_en, s_busy;
  logic [W-1:0]     s_out;
  logic [$clog2(D):0] s_cnt;
  logic             prev_en    = 1'b0;
  int               run        = 0;
  int               cyc_n      = 0;
  int               last_rise  = -1;
  bit               spacing_on = 1'b0;
  logic [W-1:0]     launched[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    bit mpush, mpop;
    @(negedge clk);
    bus_if.in_valid = v;
    bus_if.in_data  = d;
    rst             = r;
    #1;
    s_rdy  = bus_if.in_ready;
    s_en   = bus_if.src_bus_enable;
    s_busy = bus_if.busy;
    s_out  = bus_if.src_bus_out;
    s_cnt  = bus_if.fifo_count;
    check("in_ready", 32'(s_rdy), 32'(r && (mq.size() != D)));
    check("fifo_count", 32'(s_cnt), mq.size());
    check("busy", 32'(s_busy), 32'((age != 0) || (mq.size() != 0)));
    check("enable", 32'(s_en), 32'((age >= 2) && (age <= H + 1)));
    check("bus_out", 32'(s_out), 32'(m_out));
    if (s_en && !prev_en) begin
      launched.push_back(s_out);
      if (spacing_on && last_rise >= 0) check("rise_gap", cyc_n - last_rise, H + G + 2);
      last_rise = cyc_n;
    end
    if (!r) run = 0;
    else if (s_en) run++;
    else if (run > 0) begin
      check("en_len", run, H);
      run = 0;
    end
    prev_en = s_en;
    @(posedge clk);
    mpush = v && r && (mq.size() != D);
    mpop  = (age == 0) && (mq.size() != 0);
    if (!r) begin
      mq.delete();
      age   = 0;
      m_out = '0;
    end else begin
      if (mpop) begin
        m_out = mq.pop_front();
        age   = 1;
      end else if (age != 0) begin
        age = (age == H + G + 1) ? 0 : age + 1;
      end
      if (mpush) mq.push_back(d);
    end
    cyc_n++;
  endtask

  int           idx;
  bit           saw_full;
  logic         v;
  logic [W-1:0] dd;
  int           dens;

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;

    repeat (3) cyc(1'b0, '0, 1'b0);
    check("rst_cnt", 32'(s_cnt), 0);
    check("rst_rdy", 32'(s_rdy), 0);
    cyc(1'b0, '0, 1'b1);
    check("rdy_after_rst", 32'(s_rdy), 1);

    // Single word: 0xA pushed in cycle 0
    for (int c = 0; c < 12; c++) begin
      cyc(c == 0, 4'hA, 1'b1);
      if (c == 2) check("sw_out", 32'(s_out), 32'hA);
      if (c >= 3 && c <= 5) check("sw_en_hi", 32'(s_en), 1);
      if (c >= 6 && c <= 8) check("sw_en_lo", 32'(s_en), 0);
      if (c == 9) check("sw_busy", 32'(s_busy), 0);
    end

    // Burst 1..5 with in_valid held, then 0xF offered while full
    launched.delete();
    last_rise  = -1;
    spacing_on = 1'b1;
    idx        = 1;
    saw_full   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (idx <= 5) begin
        v  = 1'b1;
        dd = W'(idx);
      end else if (c < 9) begin
        v  = 1'b1;
        dd = 4'hF;
      end else begin
        v  = 1'b0;
        dd = '0;
      end
      cyc(v, dd, 1'b1);
      if (idx <= 5 && s_rdy) idx++;
      if (s_cnt == D) begin
        saw_full = 1'b1;
        check("full_rdy", 32'(s_rdy), 0);
      end
    end
    spacing_on = 1'b0;
    check("saw_full", 32'(saw_full), 1);
    check("burst_n", launched.size(), 5);
    for (int i = 0; i < launched.size(); i++) check("burst_word", 32'(launched[i]), i + 1);

    // Reset during ASSERT with two words buffered
    for (int c = 0; c < 20; c++) begin
      dd = (c == 0) ? 4'hA : ((c == 1) ? 4'hB : 4'hC);
      cyc(c <= 2, dd, c != 4);
      if (c == 4) begin
        check("pre_rst_cnt", 32'(s_cnt), 2);
        check("pre_rst_en", 32'(s_en), 1);
      end
      if (c == 5) begin
        check("abort_en", 32'(s_en), 0);
        check("abort_out", 32'(s_out), 0);
        check("abort_cnt", 32'(s_cnt), 0);
      end
      if (c > 5) check("no_launch", 32'(s_en), 0);
    end

    // Random traffic with varying density and rare resets
    dens = 50;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) dens = $urandom_range(5, 100);
      cyc($urandom_range(0, 99) < dens, W'($urandom), $urandom_range(0, 299) != 0);
    end
    repeat (40) cyc(1'b0, '0, 1'b1);
    check("drained_busy", 32'(s_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_launch_ctrl.md
BUS_LAUNCH_CTRL -- requirements
Module: bus_launch_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 4, width of data word and launched bus.
REQ-002 SHALL have parameter DEPTH, default 4, input buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter HOLD_CYCLES, default 3, cycles src_bus_enable is held high per word; >= 1.
REQ-004 SHALL have parameter GAP_CYCLES, default 3, cycles src_bus_enable is held low after each word; >= 1.
REQ-005 SHALL have CLK  input  1  single clock (source domain); all logic on rising edge.
REQ-006 SHALL have RST  input  1  reset, synchronous, active-low.
REQ-007 SHALL have in_data  input  BUS_WIDTH  word from local source logic.
REQ-008 SHALL have in_valid  input  1  in_data valid this cycle.
REQ-009 SHALL have in_ready  output  1  buffer can accept a word this cycle.
REQ-010 SHALL have src_bus_out  output  BUS_WIDTH  registered bus to the destination-domain synchronizer's unsynchronized data input.
REQ-011 SHALL have src_bus_enable  output  1  registered enable level to the destination-domain synchronizer's source-enable input.
REQ-012 SHALL have busy  output  1  word buffered or launch in progress.
REQ-013 SHALL have fifo_count  output  clog2(DEPTH)+1  words currently buffered.

Function
REQ-014 SHALL accept a word at a rising edge iff in_valid=1 and in_ready=1; in_ready = (fifo_count != DEPTH) and RST=1, with no dependence on same-cycle pop.
REQ-015 SHALL buffer words FIFO order; pointers wrap modulo DEPTH; simultaneous push and pop leaves fifo_count unchanged.
REQ-016 SHALL implement FSM states IDLE, SETUP, ASSERT, GAP.
REQ-017 IDLE: if fifo_count != 0, pop the head word into src_bus_out at this edge and go to SETUP; else stay in IDLE.
REQ-018 SETUP: lasts exactly 1 cycle, src_bus_enable=0, then ASSERT.
REQ-019 ASSERT: src_bus_enable=1 for exactly HOLD_CYCLES consecutive cycles, then GAP.
REQ-020 GAP: src_bus_enable=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-021 src_bus_enable SHALL be a flop output, high only in ASSERT.
REQ-022 src_bus_out SHALL change only on the IDLE pop edge and stay constant through SETUP, ASSERT and GAP.
REQ-023 With continuous backlog, enable rising edges SHALL be exactly 3+HOLD_CYCLES+GAP_CYCLES-1 = HOLD_CYCLES+GAP_CYCLES+2 cycles apart (one IDLE cycle per word).
REQ-024 Word pushed at edge t into an empty buffer with FSM in IDLE: popped at edge t+1, on src_bus_out from cycle t+2, enable high from cycle t+3.
REQ-025 busy = (state != IDLE) or (fifo_count != 0).
REQ-026 Writes while full SHALL be ignored; buffered contents unchanged.
REQ-027 Integration: HOLD_CYCLES SHALL cover the destination synchronizer stage count at the slowest destination clock plus one cycle; GAP_CYCLES likewise, so every word yields exactly one destination pulse.

Reset
REQ-028 While RST=0 at a rising edge: state=IDLE, fifo_count=0, pointers=0, src_bus_out=0, src_bus_enable=0, busy=0.
REQ-029 in_ready SHALL be 0 while RST=0 and 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL abort the launch (enable low next cycle) and discard all buffered words.

Verification (BUS_WIDTH=4, DEPTH=4, HOLD_CYCLES=3, GAP_CYCLES=3)
REQ-031 Single word: push 0xA in cycle 0 -> src_bus_out=0xA from cycle 2; enable=1 cycles 3-5, 0 cycles 6-8; busy=0 from cycle 9.
REQ-032 Burst: in_valid held with 0x1..0x5 -> in_ready drops to 0 while fifo_count=4; all five words output in order 1..5; each enable pulse exactly 3 cycles; rising edges 8 cycles apart.
REQ-033 Full: fifo_count=4 and in_valid=1 with 0xF -> word not accepted; 0xF never appears on src_bus_out.
REQ-034 Reset mid-ASSERT: RST=0 in cycle 4 of REQ-031 sequence with 2 words buffered -> cycle 5 enable=0, src_bus_out=0, fifo_count=0; no further launches.
REQ-035 Stability: across all runs, src_bus_out never changes while state is SETUP, ASSERT or GAP; enable never high for other than 3 consecutive cycles.
